// File: rtl/dmem_responder.sv
// dmem_responder: word-array memory model below the D-cache.
// Ports: clk, rst (sync, high); m_a/m_din/m_strobe/m_wen/m_size/m_rw in;
//   m_dout/m_ready/m_err out (registered, one ready pulse per request).
module dmem_responder #(
  parameter int A_WIDTH     = 32,
  parameter int M_INDEX     = 14,
  parameter int WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  input  logic               m_strobe,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  input  logic               m_rw,
  output logic [31:0]        m_dout,
  output logic               m_ready,
  output logic               m_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t state;
  logic [3:0] cnt;

  logic [M_INDEX+1:0] a_q;
  logic [31:0]        din_q;
  logic [3:0]         wen_q;
  logic [1:0]         size_q;
  logic               rw_q;

  logic [M_INDEX+1:0] c_a;
  logic [31:0]        c_din;
  logic [3:0]         c_wen;
  logic [1:0]         c_size;
  logic               c_rw;
  logic               c_err;
  logic               commit;
  logic               accept;
  logic [M_INDEX-1:0] idx;
  logic [31:0]        rd_word;

  logic [31:0] mem [2**M_INDEX];

  // Upper address bits alias onto the array.
  logic unused_a;
  assign unused_a = ^m_a[A_WIDTH-1:M_INDEX+2];

  assign accept = (state == IDLE) && m_strobe;

  // With zero wait states the commit edge is the accept
  // edge, so the live inputs are the request.
  always_comb begin
    if (state == IDLE) begin
      c_a    = m_a[M_INDEX+1:0];
      c_din  = m_din;
      c_wen  = m_wen;
      c_size = m_size;
      c_rw   = m_rw;
    end else begin
      c_a    = a_q;
      c_din  = din_q;
      c_wen  = wen_q;
      c_size = size_q;
      c_rw   = rw_q;
    end
  end

  always_comb begin
    commit = 1'b0;
    unique case (state)
      IDLE:    commit = ZERO_WAIT && m_strobe;
      WAIT:    commit = (cnt == 4'd0);
      default: commit = 1'b0;
    endcase
  end

  always_comb begin
    c_err = 1'b1;
    unique case (c_size)
      2'd0:    c_err = 1'b0;
      2'd1:    c_err = c_a[0];
      2'd2:    c_err = |c_a[1:0];
      default: c_err = 1'b1;
    endcase
  end

  assign idx     = c_a[M_INDEX+1:2];
  assign rd_word = mem[idx];

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= m_a[M_INDEX+1:0];
      din_q  <= m_din;
      wen_q  <= m_wen;
      size_q <= m_size;
      rw_q   <= m_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && c_rw && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wen[i]) mem[idx][8*i +: 8] <= c_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_dout  <= 32'd0;
    end else begin
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      if (commit) begin
        m_ready <= 1'b1;
        m_err   <= c_err;
        if (c_err)      m_dout <= 32'd0;
        else if (!c_rw) m_dout <= rd_word;
      end
      unique case (state)
        IDLE: begin
          if (m_strobe) begin
            cnt   <= CNT_INIT;
            state <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
